// File: rtl/arm_pkg.sv
// arm_pkg: shared register-index types and pipeline slot record for the hazard scoreboard
package arm_pkg;
    localparam int REG_W = 4;
    localparam logic [REG_W-1:0] REG_PC = 4'd15;
    typedef struct packed {
        logic             wb_en;
        logic             mem_r_en;
        logic [REG_W-1:0] dest;
    } slot_t;
endpackage

// File: rtl/sb_slot_match.sv
// sb_slot_match: flags a read-after-write conflict between one in-flight slot and the ID sources
// Ports: wb_en_i/dest_i describe the slot; src1_i/src2_i with their *_used_i flags describe
// the ID operands; match_o is high when the slot writes a register that ID actually reads.
module sb_slot_match
    import arm_pkg::*;
(
    input  logic             wb_en_i,
    input  logic [REG_W-1:0] dest_i,
    input  logic [REG_W-1:0] src1_i,
    input  logic [REG_W-1:0] src2_i,
    input  logic             src1_used_i,
    input  logic             src2_used_i,
    output logic             match_o
);
    assign match_o = wb_en_i && ((src1_used_i && dest_i == src1_i) || (src2_used_i && dest_i == src2_i));
endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: tracks in-flight destination registers and stalls ID on read-after-write hazards
// Ports: clk/rst (async, active-low); flush kills the ID instruction; id_* and src*/src*_used
// are the ID decode fields; stall freezes PC/IF-ID and bubbles ID/EXE; exe_*/mem_* expose the
// EXE and MEM slots for forwarding; stall_cnt/flush_cnt count stall and flush cycles.
module reg_scoreboard
    import arm_pkg::*;
#(
    parameter bit FWD_EN  = 1'b0,
    parameter bit WB_SLOT = 1'b0,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             id_valid,
    input  logic             id_wb_en,
    input  logic             id_mem_r_en,
    input  logic [REG_W-1:0] id_dest,
    input  logic [REG_W-1:0] src1,
    input  logic [REG_W-1:0] src2,
    input  logic             src1_used,
    input  logic             src2_used,
    output logic             stall,
    output logic [REG_W-1:0] exe_dest,
    output logic [REG_W-1:0] mem_dest,
    output logic             exe_wb_en,
    output logic             mem_wb_en,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    localparam int NSLOT = WB_SLOT ? 3 : 2;

    slot_t            slot_q [NSLOT];
    slot_t            slot0_d;
    logic [NSLOT-1:0] match;
    logic             hazard;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    for (genvar k = 0; k < NSLOT; k++) begin : g_match
        sb_slot_match u_match (
            .wb_en_i     (slot_q[k].wb_en),
            .dest_i      (slot_q[k].dest),
            .src1_i      (src1),
            .src2_i      (src2),
            .src1_used_i (src1_used),
            .src2_used_i (src2_used),
            .match_o     (match[k])
        );
    end

    // With forwarding only a load still in EXE cannot supply its result in time.
    always_comb begin
        hazard  = FWD_EN ? (match[0] && slot_q[0].mem_r_en) : |match;
        stall   = hazard && id_valid && !flush;
        slot0_d = '0;
        if (id_valid && !stall && !flush)
            slot0_d = slot_t'{wb_en: id_wb_en, mem_r_en: id_mem_r_en, dest: id_dest};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NSLOT; i++) slot_q[i] <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            slot_q[0] <= slot0_d;
            for (int i = 1; i < NSLOT; i++) slot_q[i] <= slot_q[i-1];
            if (stall) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (flush) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign exe_dest  = slot_q[0].dest;
    assign exe_wb_en = slot_q[0].wb_en;
    assign mem_dest  = slot_q[1].dest;
    assign mem_wb_en = slot_q[1].wb_en;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard: scoreboard bench driving three scoreboard variants from shared ID inputs
module tb_reg_scoreboard;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       flush = 1'b0, id_valid = 1'b0, id_wb_en = 1'b0, id_mem_r_en = 1'b0;
    logic       src1_used = 1'b0, src2_used = 1'b0;
    logic [3:0] id_dest = '0, src1 = '0, src2 = '0;

    logic [2:0]  stall, exe_wb_en, mem_wb_en;
    logic [3:0]  exe_dest [3];
    logic [3:0]  mem_dest [3];
    logic [31:0] sc0, fc0, sc2, fc2;
    logic [7:0]  sc1, fc1;

    always #5 clk = ~clk;

    // u0: no forwarding; u1: forwarding with 8-bit counters; u2: no forwarding plus WB slot
    reg_scoreboard #(.FWD_EN(1'b0), .WB_SLOT(1'b0), .CNT_W(32)) u0 (
        .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid), .id_wb_en(id_wb_en),
        .id_mem_r_en(id_mem_r_en), .id_dest(id_dest), .src1(src1), .src2(src2),
        .src1_used(src1_used), .src2_used(src2_used), .stall(stall[0]),
        .exe_dest(exe_dest[0]), .mem_dest(mem_dest[0]), .exe_wb_en(exe_wb_en[0]),
        .mem_wb_en(mem_wb_en[0]), .stall_cnt(sc0), .flush_cnt(fc0));
    reg_scoreboard #(.FWD_EN(1'b1), .WB_SLOT(1'b0), .CNT_W(8)) u1 (
        .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid), .id_wb_en(id_wb_en),
        .id_mem_r_en(id_mem_r_en), .id_dest(id_dest), .src1(src1), .src2(src2),
        .src1_used(src1_used), .src2_used(src2_used), .stall(stall[1]),
        .exe_dest(exe_dest[1]), .mem_dest(mem_dest[1]), .exe_wb_en(exe_wb_en[1]),
        .mem_wb_en(mem_wb_en[1]), .stall_cnt(sc1), .flush_cnt(fc1));
    reg_scoreboard #(.FWD_EN(1'b0), .WB_SLOT(1'b1), .CNT_W(32)) u2 (
        .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid), .id_wb_en(id_wb_en),
        .id_mem_r_en(id_mem_r_en), .id_dest(id_dest), .src1(src1), .src2(src2),
        .src1_used(src1_used), .src2_used(src2_used), .stall(stall[2]),
        .exe_dest(exe_dest[2]), .mem_dest(mem_dest[2]), .exe_wb_en(exe_wb_en[2]),
        .mem_wb_en(mem_wb_en[2]), .stall_cnt(sc2), .flush_cnt(fc2));

    typedef struct {
        string       name;
        int          d;
        logic        st;
        logic [3:0]  ed;
        logic        ew;
        logic [3:0]  md;
        logic        mw;
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic ex(input string name, input int d, input logic st, input logic [3:0] ed,
                      input logic ew, input logic [3:0] md, input logic mw,
                      input logic [31:0] sc, input logic [31:0] fc);
        q.push_back('{name, d, st, ed, ew, md, mw, sc, fc});
    endtask

    task automatic id(input logic v, input logic wb, input logic mr, input logic [3:0] d,
                      input logic [3:0] s1, input logic [3:0] s2, input logic u1,
                      input logic u2, input logic fl);
        id_valid = v; id_wb_en = wb; id_mem_r_en = mr; id_dest = d;
        src1 = s1; src2 = s2; src1_used = u1; src2_used = u2; flush = fl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    // Monitor: every expectation queued during a cycle is checked at that cycle's falling edge.
    initial forever begin
        @(negedge clk);
        while (q.size() > 0) begin
            exp_t        e;
            logic [31:0] asc, afc;
            e   = q.pop_front();
            asc = e.d == 0 ? sc0 : e.d == 1 ? {24'd0, sc1} : sc2;
            afc = e.d == 0 ? fc0 : e.d == 1 ? {24'd0, fc1} : fc2;
            n_cmp++;
            if ({stall[e.d], exe_dest[e.d], exe_wb_en[e.d], mem_dest[e.d], mem_wb_en[e.d], asc, afc}
                !== {e.st, e.ed, e.ew, e.md, e.mw, e.sc, e.fc}) begin
                n_bad++;
                $display("FAIL %s u%0d: got stall=%b exe=%0d/%b mem=%0d/%b sc=%0d fc=%0d, want stall=%b exe=%0d/%b mem=%0d/%b sc=%0d fc=%0d",
                         e.name, e.d, stall[e.d], exe_dest[e.d], exe_wb_en[e.d], mem_dest[e.d],
                         mem_wb_en[e.d], asc, afc, e.st, e.ed, e.ew, e.md, e.mw, e.sc, e.fc);
            end
        end
    end

    initial begin
        step();
        for (int d = 0; d < 3; d++) ex("rst_hold", d, 0, 0, 0, 0, 0, 0, 0);
        step();
        for (int d = 0; d < 3; d++) ex("rst_hold2", d, 0, 0, 0, 0, 0, 0, 0);
        step();
        rst = 1'b1;
        for (int d = 0; d < 3; d++) ex("idle", d, 0, 0, 0, 0, 0, 0, 0);
        step();

        // RAW: ADD R1 then a reader of R1 held in ID
        do_reset();
        id(1, 1, 0, 1, 0, 0, 0, 0, 0);
        ex("raw_issue", 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        id(1, 1, 0, 2, 1, 0, 1, 0, 0);
        ex("raw_stall1", 0, 1, 1, 1, 0, 0, 0, 0);
        ex("raw_stall1", 2, 1, 1, 1, 0, 0, 0, 0);
        ex("fwd_alu_nostall", 1, 0, 1, 1, 0, 0, 0, 0);
        step();
        ex("raw_stall2", 0, 1, 0, 0, 1, 1, 1, 0);
        ex("raw_stall2", 2, 1, 0, 0, 1, 1, 1, 0);
        step();
        ex("raw_release", 0, 0, 0, 0, 0, 0, 2, 0);
        ex("wb_stall3", 2, 1, 0, 0, 0, 0, 2, 0);
        step();
        ex("raw_reissue", 0, 0, 2, 1, 0, 0, 2, 0);
        ex("wb_release", 2, 0, 0, 0, 0, 0, 3, 0);
        step();
        id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        ex("raw_drain", 0, 0, 2, 1, 2, 1, 2, 0);
        ex("wb_drain", 2, 0, 2, 1, 0, 0, 3, 0);
        step();

        // Load-use with forwarding, then the same with an ALU producer
        do_reset();
        id(1, 1, 1, 3, 0, 0, 0, 0, 0);
        ex("ldr_issue", 1, 0, 0, 0, 0, 0, 0, 0);
        step();
        id(1, 1, 0, 4, 0, 3, 0, 1, 0);
        ex("load_use", 1, 1, 3, 1, 0, 0, 0, 0);
        step();
        ex("load_use_done", 1, 0, 0, 0, 3, 1, 1, 0);
        step();
        id(1, 1, 0, 3, 0, 0, 0, 0, 0);
        ex("add_issue", 1, 0, 4, 1, 0, 0, 1, 0);
        step();
        id(1, 1, 0, 5, 0, 3, 0, 1, 0);
        ex("add_use", 1, 0, 3, 1, 4, 1, 1, 0);
        step();
        id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        ex("add_drain", 1, 0, 5, 1, 3, 1, 1, 0);
        step();

        // Unused-source filter, store reading Rd, flush priority
        do_reset();
        id(1, 1, 0, 5, 0, 0, 0, 0, 0);
        ex("r5_issue", 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        id(1, 1, 0, 6, 5, 0, 0, 0, 0);
        ex("unused_src", 0, 0, 5, 1, 0, 0, 0, 0);
        step();
        id(1, 0, 0, 0, 0, 5, 0, 1, 0);
        ex("store_rd", 0, 1, 6, 1, 5, 1, 0, 0);
        step();
        id(1, 1, 0, 8, 6, 5, 1, 1, 1);
        ex("flush_prio", 0, 0, 0, 0, 6, 1, 1, 0);
        step();
        id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        ex("flush_bubble", 0, 0, 0, 0, 0, 0, 1, 1);
        step();

        // Double-source hazard, then async reset in the middle of a stall
        do_reset();
        id(1, 1, 0, 7, 0, 0, 0, 0, 0);
        ex("r7_issue", 0, 0, 0, 0, 0, 0, 0, 0);
        ex("r7_issue", 2, 0, 0, 0, 0, 0, 0, 0);
        step();
        id(1, 1, 0, 8, 7, 7, 1, 1, 0);
        ex("dual_src1", 0, 1, 7, 1, 0, 0, 0, 0);
        ex("dual_src1", 2, 1, 7, 1, 0, 0, 0, 0);
        step();
        ex("dual_src2", 0, 1, 0, 0, 7, 1, 1, 0);
        ex("dual_src2", 2, 1, 0, 0, 7, 1, 1, 0);
        step();
        #2;
        rst = 1'b0;
        ex("async_rst", 0, 0, 0, 0, 0, 0, 0, 0);
        ex("async_rst", 2, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        step();
        ex("after_rst", 2, 0, 8, 1, 0, 0, 0, 0);
        step();

        // flush_cnt wrap on the 8-bit instance
        do_reset();
        id(0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 1; i <= 256; i++) begin
            if (i == 1) ex("fcnt_start", 1, 0, 0, 0, 0, 0, 0, 0);
            if (i == 256) begin
                ex("fcnt_max", 1, 0, 0, 0, 0, 0, 0, 255);
                ex("fcnt_255", 0, 0, 0, 0, 0, 0, 0, 255);
            end
            step();
        end
        id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        ex("fcnt_wrap", 1, 0, 0, 0, 0, 0, 0, 0);
        ex("fcnt_256", 0, 0, 0, 0, 0, 0, 0, 256);
        step();

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Hazard tracker that mirrors the in-flight destination registers in the EXE and MEM stages, and optionally WB.
- Compares them against the source registers of the instruction currently in ID.
- Drives `stall`, which freezes the PC and IF/ID register and forces a bubble into the ID/EXE register.
- Sits beside the ID stage and consumes the same decode fields that are latched into the ID/EXE register.

Parameters:
- FWD_EN, 0: 1 = a forwarding unit exists, so only a load in the EXE slot stalls; 0 = any pending write to a source stalls.
- WB_SLOT, 0: 1 = a third slot tracks the WB stage (for a register file without write-before-read).
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous reset, active-low
- flush  in  1  branch taken in EXE; the instruction in ID is wrong-path
- id_valid  in  1  ID holds a real instruction
- id_wb_en  in  1  ID instruction writes the register file
- id_mem_r_en  in  1  ID instruction is a load
- id_dest  in  4  ID destination register
- src1  in  4  Rn
- src2  in  4  Rm (or Rd for stores)
- src1_used  in  1  Rn is read
- src2_used  in  1  src2 is read (register operand, or store)
- stall  out  1  hazard present; freeze PC/IF-ID, bubble ID/EXE
- exe_dest  out  4  destination in EXE slot (for the forwarding unit)
- mem_dest  out  4  destination in MEM slot
- exe_wb_en  out  1  EXE slot valid and writes back
- mem_wb_en  out  1  MEM slot valid and writes back
- stall_cnt  out  CNT_W  cycles with stall=1
- flush_cnt  out  CNT_W  cycles with flush=1

Behaviour:
- State: slot 0 (EXE), slot 1 (MEM), and slot 2 (WB, present only if WB_SLOT=1). Each slot holds {wb_en, mem_r_en, dest}; a slot with wb_en=0 is a bubble.
- Reset (rst=0, async): all slot fields 0, both counters 0. Outputs therefore read stall=0, exe/mem_dest=0, exe/mem_wb_en=0.
- Match for slot k: slot.wb_en && dest==src1 && src1_used, or the same condition for src2/src2_used.
- Hazard (combinational, same cycle as ID inputs):
  - FWD_EN=0: match on any present slot.
  - FWD_EN=1: match on slot 0 with slot0.mem_r_en=1.
- stall = hazard && id_valid && !flush. Flush has priority: a wrong-path instruction never stalls.
- Per posedge, slot 0 receives:
  - {id_wb_en, id_mem_r_en, id_dest} if id_valid && !stall && !flush;
  - otherwise a bubble (all zero).
- Per posedge, slot 1 <= slot 0 and slot 2 <= slot 1, unconditionally. Later stages never stall.
- Timing: exe_*/mem_* outputs are registered and reflect slot contents, giving 1-cycle latency from issue to exe_dest. The stall decision is combinational with 0-cycle latency.
- Load-use with FWD_EN=1 gives exactly 1 stall cycle. Without forwarding, a dependent instruction directly behind its producer stalls 2 cycles (3 if WB_SLOT=1).
- Register 15 (PC) is compared like any other register; decode deasserts srcN_used when the PC is implied.
- Counters: stall_cnt increments when stall=1 and flush_cnt when flush=1. Both wrap at 2^CNT_W with no saturation.
- Reset asserted mid-stall: slots clear immediately, so stall drops in the same cycle, asynchronously.
- Simultaneous src1 and src2 hazards produce a single stall; there is no double counting.

Decomposition:
- Shared package `arm_pkg`: the slot record type {wb_en, mem_r_en, dest[3:0]}, REG_PC=4'd15, and the register index width constant.
- One natural sub-module, `sb_slot_match`: compares one slot against src1/src2/used flags and returns its match bit. Instantiate it per slot.

Test Plan:
- Reset then idle: rst=0 for 2 cycles, then id_valid=0 -> stall=0, all dests 0, stall_cnt=0.
- RAW without forwarding (FWD_EN=0):
  - Issue ADD R1 (wb_en=1, dest=1); next cycle ID has src1=1, src1_used=1.
  - Required: stall=1 for 2 cycles, then the instruction issues; stall_cnt=2.
- Load-use with forwarding (FWD_EN=1):
  - Issue LDR R3 (mem_r_en=1, dest=3); next cycle src2=3, src2_used=1.
  - Required: stall=1 for exactly 1 cycle.
  - Repeat with ADD R3 instead of LDR -> stall=0.
- Flush priority: hazard present and flush=1 in the same cycle -> stall=0, slot 0 becomes a bubble (exe_wb_en=0 next cycle), flush_cnt=1.
- Unused-source filter: pending dest=5 with src1=5 but src1_used=0 -> stall=0; also cover a store with src2=Rd=5, src2_used=1 -> stall=1.
- Async reset mid-stall: during a stall, pulse rst low between clock edges -> stall drops immediately, slots clear, and both counters read 0.
